dm_ram: RTL and testbench
=========================

Name: dm_ram

Overview:
- Word-organised data memory with per-byte write enables. Sits directly downstream of the load/store byte-lane controller: it takes that controller's lane-replicated store data and 4-bit byte-write mask, and returns the raw 32-bit word that the controller sign- or zero-extends.
- Access is multi-cycle, with a programmable wait count and a req/busy/done handshake, so the core can model a slow memory.
- The memory array is not reset; only the control path is.

Parameters:
- ADDR_WIDTH, 8: word-address bits. Depth = 2**ADDR_WIDTH words.
- WAIT_CYCLES, 1: extra wait cycles before the array access. Legal range 0..15.

Ports:
- clk  in  1: clock. All logic is rising-edge.
- rst  in  1: asynchronous reset, active-high.
- req  in  1: access request. Sampled only while busy=0.
- we  in  1: 1 = write, 0 = read.
- wea  in  4: byte write enables. Bit i writes din[8i+7:8i]. Ignored when we=0.
- addr  in  32: byte address. The word index is addr[ADDR_WIDTH+1:2]. addr[1:0] and the upper bits are ignored.
- din  in  32: write data, already lane-replicated by the upstream controller.
- dout  out  32: read word. Holds its value until the next read completes.
- busy  out  1: high while an access is in flight.
- done  out  1: one-cycle pulse when an access completes.
- err  out  1: illegal write-mask flag. See Optional Feature.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, wait counter=0, dout=0, busy=0, done=0, err=0, latched request registers cleared.
  - Array contents are untouched.
- FSM states: IDLE, WAIT, RESP.
  - busy=1 in WAIT and RESP.
  - done=1 only in RESP.
- IDLE:
  - If req=1 in cycle T, latch we, wea, word index and din at the edge ending T, load counter=WAIT_CYCLES, and go to WAIT.
  - If req=0, stay in IDLE.
- WAIT:
  - counter≠0: decrement and stay.
  - counter=0: perform the array access at this edge and go to RESP.
  - Write: for each i with latched wea[i]=1, mem[idx][8i+7:8i] ← din[8i+7:8i]. Other bytes are unchanged.
  - Read: dout ← mem[idx], all 32 bits.
- RESP: done=1 for exactly one cycle, then go to IDLE. A new req is accepted in the following IDLE cycle, never in RESP.
- Latency:
  - Accept in cycle T; done is high in cycle T+WAIT_CYCLES+2.
  - With WAIT_CYCLES=0 the throughput is one access per 3 cycles.
- req while busy=1: ignored, not queued. The requester must hold or re-issue it.
- Input changes after acceptance have no effect, because all inputs are latched.
- Write with wea=4'b0000: no bytes change, done still pulses, dout is unchanged.
- A write never alters dout.
- Address wrap: the index is taken modulo depth. Addresses idx and idx + depth*4 alias.
- Reset mid-operation: the in-flight access is aborted.
  - A write whose access edge has not yet occurred is dropped.
  - A write already committed stays committed.
  - No done pulse is produced for the aborted access.
- Read-after-write to the same word: the read, accepted after the write's done, returns the merged word.

Optional Feature:
- Macro: DM_WEA_CHECK_EN.
- Defined:
  - At acceptance, a write (we=1) whose wea is not one of 1111, 0011, 1100, 0001, 0010, 0100, 1000, 0000 is flagged illegal.
  - An illegal access still runs through WAIT/RESP with normal timing.
  - The array is not written.
  - err=1 in the RESP cycle, together with done.
  - Reads never flag.
- Not defined: err is tied to 0, and any wea pattern is written byte-wise as specified.

Test Plan:
1. Reset, then read addr 0x0 with WAIT_CYCLES=1 -> busy goes high at T+1; done pulses at T+3; dout = contents of array word 0 (zero after X-free init preload).
2. Write 0xAABBCCDD, wea=1111, addr 0x10; then write din=0x11111111, wea=0100, addr 0x12; then read 0x10 -> dout=0xAA11CCDD.
3. Assert req for 5 consecutive cycles with a single write -> exactly one access and one done pulse; re-issued req after done is accepted.
4. Assert rst in the cycle after acceptance of a write to 0x20 (WAIT_CYCLES=3), then read 0x20 -> old value retained; no done pulse for the aborted write; dout=0 right after reset.
5. Write 0x12345678 at byte address (4<<ADDR_WIDTH)+8, then read 0x8 -> 0x12345678 (wrap-around).
6. With DM_WEA_CHECK_EN: write wea=0110, din=0xFFFFFFFF, addr 0x30 -> err=1 and done=1 in the same cycle; subsequent read of 0x30 is unchanged. Without the macro: bytes 1 and 2 of the word become 0xFF.

Source files
------------

// File: rtl/dm_ram.sv
// rtl/dm_ram.sv - word-organised data memory with byte write enables and a programmable wait count
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (control path only, array untouched)
//   req  : access request, sampled only while busy=0
//   we   : 1 = write, 0 = read
//   wea  : byte write enables, bit i covers din[8i+7:8i]
//   addr : byte address, word index = addr[ADDR_WIDTH+1:2]
//   din  : lane-replicated write data
//   dout : last read word, held until the next read completes
//   busy : access in flight (WAIT or RESP)
//   done : one-cycle completion pulse (RESP)
//   err  : illegal write-mask flag, valid with done
//
// Optional feature macro: DM_WEA_CHECK_EN (write-mask legality check).
// When undefined, err is tied low and any mask is written byte-wise.

module dm_ram #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  wea,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [3:0]              wea_q, wea_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             din_q, din_d;
    logic [31:0]             dout_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    accept;
    logic                    access;
    logic                    wr_ok;
    logic                    err_flag;

    // Only the word-index bits of the byte address are meaningful.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

    assign accept = (state_q == S_IDLE) && req;
    // The array access happens on the edge that leaves WAIT.
    assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);

`ifdef DM_WEA_CHECK_EN
    logic ill_q, ill_d;

    function automatic logic wea_legal(input logic [3:0] m);
        case (m)
            4'b1111, 4'b0011, 4'b1100, 4'b0000,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wea_legal = 1'b1;
            default:                            wea_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        ill_d = ill_q;
        if (accept) begin
            ill_d = we && !wea_legal(wea);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= ill_d;
        end
    end

    assign wr_ok    = !ill_q;
    assign err_flag = ill_q;
`else
    assign wr_ok    = 1'b1;
    assign err_flag = 1'b0;
`endif

    // State and latched-request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            wea_q   <= 4'd0;
            idx_q   <= '0;
            din_q   <= 32'd0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wea_q   <= wea_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
            if (access && !we_q) begin
                dout_q <= mem_q[idx_q];
            end
        end
    end

    // Array is deliberately not reset. An async reset forces state_q to
    // IDLE, which removes the access condition for a not-yet-committed write.
    always_ff @(posedge clk) begin
        if (access && we_q && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wea_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= din_q[8*i +: 8];
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        wea_d   = wea_q;
        idx_d   = idx_q;
        din_d   = din_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                    we_d    = we;
                    wea_d   = wea;
                    idx_d   = addr[ADDR_WIDTH+1:2];
                    din_d   = din;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        case (state_q)
            S_WAIT: busy = 1'b1;
            S_RESP: begin
                busy = 1'b1;
                done = 1'b1;
                err  = err_flag;
            end
            default: ;
        endcase
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_dm_ram.sv
// tb/tb_dm_ram.sv - directed self-checking bench for dm_ram

module tb_dm_ram;

    localparam int AW = 8;
    localparam int WC = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  wea = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    dm_ram #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .we   (we),
        .wea  (wea),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One complete access; inputs are scrambled right after acceptance so a
    // design that fails to latch them is caught.
    task automatic access(input logic w, input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] d, output logic e);
        int lat;
        @(posedge clk); #1;
        req = 1'b1; we = w; wea = m; addr = a; din = d;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; wea = ~m; addr = ~a; din = ~d;
        check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        e = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                e = err;
                break;
            end
        end
        check_eq("latency", lat, WC + 2);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic e;
        access(1'b0, 4'hF, a, 32'd0, e);
        check_eq(tag, dout, exp);
        check_eq({tag, "_err"}, {31'd0, e}, 32'd0);
    endtask

    task automatic wr(input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
        logic e;
        access(1'b1, m, a, d, e);
    endtask

    initial begin
        int dn;
        logic e;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_dout", dout, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic write / read of word 0
        wr(4'hF, 32'h0, 32'hCAFEF00D);
        rd(32'h0, 32'hCAFEF00D, "rd_w0");

        // Byte-merge
        wr(4'hF, 32'h10, 32'hAABBCCDD);
        wr(4'b0100, 32'h12, 32'h11111111);
        check_eq("write_keeps_dout", dout, 32'hCAFEF00D);
        rd(32'h10, 32'hAA11CCDD, "rd_merge");

        // Empty mask: nothing written, done still pulses, dout held
        wr(4'b0000, 32'h10, 32'hFFFFFFFF);
        check_eq("wea0_dout", dout, 32'hAA11CCDD);
        rd(32'h10, 32'hAA11CCDD, "rd_wea0");

        // req held through the whole access: exactly one done
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; wea = 4'hF; addr = 32'h40; din = 32'h55AA55AA;
        dn = 0;
        for (int k = 0; k < WC + 3; k++) begin
            @(negedge clk);
            dn += int'(done);
            @(posedge clk);
        end
        #1 req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dn += int'(done);
        end
        check_eq("held_req_dones", dn, 1);
        rd(32'h40, 32'h55AA55AA, "rd_reissue");

        // Reset mid-write aborts the write
        wr(4'hF, 32'h20, 32'h0BADBEEF);
        rd(32'h20, 32'h0BADBEEF, "rd_pre_abort");
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; wea = 4'hF; addr = 32'h20; din = 32'hDEADDEAD;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_dout", dout, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        dn = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dn += int'(done);
        end
        check_eq("abort_no_done", dn, 0);
        rd(32'h20, 32'h0BADBEEF, "rd_post_abort");

        // Address wrap
        wr(4'hF, (32'd4 << AW) + 32'd8, 32'h12345678);
        rd(32'h8, 32'h12345678, "rd_wrap");

        // Non-contiguous mask
        wr(4'hF, 32'h30, 32'h01020304);
        access(1'b1, 4'b0110, 32'h30, 32'hFFFFFFFF, e);
`ifdef DM_WEA_CHECK_EN
        check_eq("mask_err", {31'd0, e}, 32'd1);
        rd(32'h30, 32'h01020304, "rd_mask");
`else
        check_eq("mask_err", {31'd0, e}, 32'd0);
        rd(32'h30, 32'h01FFFF04, "rd_mask");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
